lc3b_mem_arbiter: RTL
=====================

Name: lc3b_mem_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch requester (I) and the data load/store requester (D) of the LC-3b core.
- Sits between the control/datapath memory interface and physical memory.
- Both requester ports use the existing level handshake: read or write is held high until resp is seen.
- Grants one requester at a time, forwards its transaction, and routes resp/rdata back to the granted requester only.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width; byte-enable width is DATA_W/8.
- D_PRIORITY, 1, fixed-priority winner on simultaneous request: 1 = D wins, 0 = I wins.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  instruction read request, held until i_resp
- i_address  in  ADDR_W  instruction address
- i_resp  out  1  instruction transaction complete
- i_rdata  out  DATA_W  instruction read data
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write data
- d_byte_enable  in  DATA_W/8  write byte mask
- d_resp  out  1  data transaction complete
- d_rdata  out  DATA_W  data read data
- pmem_read  out  1  downstream read
- pmem_write  out  1  downstream write
- pmem_address  out  ADDR_W  downstream address
- pmem_wdata  out  DATA_W  downstream write data
- pmem_byte_enable  out  DATA_W/8  downstream mask
- pmem_resp  in  1  downstream completion
- pmem_rdata  in  DATA_W  downstream read data
- busy  out  1  high while in S_GNT_I or S_GNT_D

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset forces state to S_IDLE and clears the registered grant. While in reset, all outputs are 0.
- States and transitions:
  - S_IDLE: no downstream request; all outputs 0.
    - Only D requesting (d_read|d_write) -> S_GNT_D.
    - Only I requesting (i_read) -> S_GNT_I.
    - Both requesting -> S_GNT_D if D_PRIORITY=1, else S_GNT_I.
  - S_GNT_I: pmem_read = i_read; pmem_address = i_address; pmem_write = 0; wdata and byte_enable are 0.
    - i_resp = pmem_resp combinationally; i_rdata = pmem_rdata.
    - On pmem_resp -> S_IDLE.
  - S_GNT_D: pmem_read = d_read; pmem_write = d_write & ~d_read; address, wdata and byte_enable are passed through from D.
    - d_resp = pmem_resp; d_rdata = pmem_rdata.
    - On pmem_resp -> S_IDLE.
- Latency:
  - A request sampled in S_IDLE at edge N drives pmem_* from cycle N+1.
  - resp reaches the requester in the same cycle as pmem_resp.
  - S_IDLE always occupies one cycle between grants, so a requester's deasserting request is never re-granted.
- Non-granted requester: its resp is 0 and its rdata is 0; it keeps waiting and is never dropped.
- Simultaneous read and write on D: read wins, write is suppressed.
- Granted requester deasserts without pmem_resp (abort): downstream read/write drop in the same cycle and the state returns to S_IDLE at the next edge.
- pmem_resp while in S_IDLE is ignored.
- rst_n asserted mid-transaction: downstream read/write drop immediately and the transaction is lost. The requester's own reset is responsible for retry.

Optional Feature:
- MEMARB_RR_EN defined: the D_PRIORITY fixed priority is replaced by round-robin.
  - A 1-bit last_grant register is reset to I.
  - On a tie, the requester not granted last is granted.
  - last_grant updates on every grant.
- MEMARB_RR_EN undefined: fixed priority per D_PRIORITY, and no last_grant flop exists.

Test Plan:
- I-only read, address 0x0040, pmem_resp after 3 cycles with rdata 0x1234:
  - pmem_read high from cycle 1.
  - i_resp=1 and i_rdata=0x1234 in the resp cycle.
  - busy falls next cycle.
  - d_resp stays 0 throughout.
- D write, address 0x0102, wdata 0xBEEF, mask 2'b01:
  - pmem_write=1, pmem_byte_enable=01, pmem_wdata=0xBEEF.
  - d_resp mirrors pmem_resp.
- Simultaneous i_read and d_read with D_PRIORITY=1:
  - D is served first.
  - One S_IDLE cycle follows.
  - I is then served; i_resp only follows its own pmem_resp.
- With MEMARB_RR_EN, four back-to-back tied requests -> grant order D, I, D, I (first grant D because last_grant resets to I).
- rst_n pulsed low while in S_GNT_D -> pmem_read and pmem_write go 0 asynchronously; after release, state is S_IDLE and busy=0.
- D asserts d_read and d_write together -> pmem_read=1 and pmem_write=0.

Source files
------------

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one physical memory port between the LC-3b
// instruction-fetch requester (I) and the data load/store requester (D).
// One requester owns the port at a time. Its transaction is forwarded
// downstream, and resp/rdata go back to that requester only.
// There is always one idle cycle between grants, so a requester that has
// just deasserted its request cannot be granted again.
// Optional build macro: MEMARB_RR_EN. When it is defined, a tie is broken by
// round-robin on a last_grant flop instead of the fixed D_PRIORITY order.
module lc3b_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int D_PRIORITY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_resp,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_enable,
  output logic                d_resp,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GNT_I = 2'b01;
  localparam logic [1:0] S_GNT_D = 2'b10;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_i_req;
  logic       w_d_req;
  logic       w_tie_d;
  logic       w_pick_d;

  assign w_i_req  = i_read;
  assign w_d_req  = d_read | d_write;
  assign w_pick_d = w_d_req & (~w_i_req | w_tie_d);

`ifdef MEMARB_RR_EN
  // r_last_d is 1 when the most recent grant went to D.
  logic r_last_d;

  assign w_tie_d = ~r_last_d;

  // Record the winner each time a grant is issued from idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if ((r_state == S_IDLE) && (w_i_req | w_d_req)) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_tie_d = (D_PRIORITY != 0);
`endif

  // Choose the next owner from idle; release on completion or abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_i_req | w_d_req) begin
          w_state_nxt = w_pick_d ? S_GNT_D : S_GNT_I;
        end
      end
      S_GNT_I: begin
        if (pmem_resp | ~w_i_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GNT_D: begin
        if (pmem_resp | ~w_d_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The state register is the registered grant. Reset returns it to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Steer the owner's request downstream and the response back to it.
  // Request levels pass straight through, so an abort drops them at once.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    i_resp           = 1'b0;
    i_rdata          = '0;
    d_resp           = 1'b0;
    d_rdata          = '0;
    busy             = 1'b0;
    case (r_state)
      S_GNT_I: begin
        busy         = 1'b1;
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        i_rdata      = pmem_rdata;
      end
      S_GNT_D: begin
        busy             = 1'b1;
        pmem_read        = d_read;
        pmem_write       = d_write & ~d_read;
        pmem_address     = d_address;
        pmem_wdata       = d_wdata;
        pmem_byte_enable = d_byte_enable;
        d_resp           = pmem_resp;
        d_rdata          = pmem_rdata;
      end
      default: ;
    endcase
  end

endmodule
